// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM: owns the pointers, the occupancy count and the flags.
// Read data returns one clock after read_en and is presented on pop_data with pop_valid.
module dpram_fifo_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  write_en,
   output logic [ADDR_WIDTH-1:0] WAdddr,
   output logic [DATA_WIDTH-1:0] dataIn,
   output logic                  read_en,
   output logic [ADDR_WIDTH-1:0] RAdddr,
   input  logic [DATA_WIDTH-1:0] dataOut
);

   localparam logic [ADDR_WIDTH:0]   DepthCount = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CountOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PtrOne     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [ADDR_WIDTH-1:0] wrPtr;
   logic [ADDR_WIDTH-1:0] rdPtr;
   logic [ADDR_WIDTH:0]   countReg;
   logic                  popValidReg;
   logic                  overflowReg;
   logic                  underflowReg;
   logic                  pushOk;
   logic                  popOk;

   // Flags come from the registered count only, so a simultaneous push/pop never bypasses.
   assign full   = (countReg == DepthCount);
   assign empty  = (countReg == '0);
   assign pushOk = push && !full && !rst;
   assign popOk  = pop && !empty && !rst;

   assign write_en  = pushOk;
   assign WAdddr    = wrPtr;
   assign dataIn    = push_data;
   assign read_en   = popOk;
   assign RAdddr    = rdPtr;
   assign count     = countReg;
   assign pop_valid = popValidReg;
   assign pop_data  = popValidReg ? dataOut : '0;
   assign overflow  = overflowReg;
   assign underflow = underflowReg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr        <= '0;
         rdPtr        <= '0;
         countReg     <= '0;
         popValidReg  <= 1'b0;
         overflowReg  <= 1'b0;
         underflowReg <= 1'b0;
      end else begin
         popValidReg <= popOk;
         if (pushOk) wrPtr <= wrPtr + PtrOne;
         if (popOk)  rdPtr <= rdPtr + PtrOne;
         case ({pushOk, popOk})
            2'b10:   countReg <= countReg + CountOne;
            2'b01:   countReg <= countReg - CountOne;
            default: countReg <= countReg;
         endcase
         if (push && full)  overflowReg  <= 1'b1;
         if (pop && empty)  underflowReg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl (depth 4) with a behavioural DPRAM and a pop_data scoreboard.
// Stimulus queues the expected dequeued byte; a negedge monitor compares it when pop_valid appears.
module tb_dpram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push = 1'b0;
   logic [7:0] push_data = '0;
   logic       pop = 1'b0;
   logic [7:0] pop_data;
   logic       pop_valid;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic       overflow;
   logic       underflow;
   logic       write_en;
   logic [1:0] WAdddr;
   logic [7:0] dataIn;
   logic       read_en;
   logic [1:0] RAdddr;
   logic [7:0] dataOut = '0;

   logic [7:0] mem [4];
   logic [7:0] expQ [$];
   int checks = 0;
   int errors = 0;

   dpram_fifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
      .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
      .count(count), .overflow(overflow), .underflow(underflow),
      .write_en(write_en), .WAdddr(WAdddr), .dataIn(dataIn),
      .read_en(read_en), .RAdddr(RAdddr), .dataOut(dataOut)
   );

   always #5 clk = ~clk;

   // Behavioural DPRAM: synchronous write, registered read.
   always @(posedge clk) begin
      if (write_en) mem[WAdddr] <= dataIn;
      if (read_en)  dataOut     <= mem[RAdddr];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (pop_valid === 1'b1) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL pop_valid_unexpected: got data %0h expected no pop_valid at %0t", pop_data, $time);
         end else begin
            logic [7:0] e;
            e = expQ.pop_front();
            if (pop_data !== e) begin
               errors++;
               $display("[TB] FAIL pop_data: got %0h expected %0h at %0t", pop_data, e, $time);
            end
         end
      end
   end

   // Drive one clock of push/pop (called at a negedge), check the combinational strobes, advance to next negedge.
   task automatic applyStimulus(input logic pu, input logic [7:0] d, input logic po,
                                input logic expWe, input logic [1:0] expWa,
                                input logic expRe, input logic [1:0] expRa, input logic [7:0] expData);
      push = pu; push_data = d; pop = po;
      #1;
      checkOutput("write_en", 32'(write_en), 32'(expWe));
      if (expWe) begin
         checkOutput("WAdddr", 32'(WAdddr), 32'(expWa));
         checkOutput("dataIn", 32'(dataIn), 32'(d));
      end
      checkOutput("read_en", 32'(read_en), 32'(expRe));
      if (expRe) begin
         checkOutput("RAdddr", 32'(RAdddr), 32'(expRa));
         expQ.push_back(expData);
      end
      @(posedge clk);
      @(negedge clk);
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic checkState(input logic [2:0] c, input logic f, input logic e, input logic ov, input logic un);
      checkOutput("count", 32'(count), 32'(c));
      checkOutput("full", 32'(full), 32'(f));
      checkOutput("empty", 32'(empty), 32'(e));
      checkOutput("overflow", 32'(overflow), 32'(ov));
      checkOutput("underflow", 32'(underflow), 32'(un));
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      expQ.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Strobes stay low during reset even with requests asserted.
      push = 1'b1; pop = 1'b1; push_data = 8'hEE;
      @(negedge clk);
      #1;
      checkOutput("write_en_in_reset", 32'(write_en), 32'd0);
      checkOutput("read_en_in_reset", 32'(read_en), 32'd0);
      push = 1'b0; pop = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkState(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("pop_valid_reset", 32'(pop_valid), 32'd0);

      // Fill, then overflow.
      applyStimulus(1, 8'h11, 0, 1, 2'd0, 0, 2'd0, 8'h00);
      applyStimulus(1, 8'h22, 0, 1, 2'd1, 0, 2'd0, 8'h00);
      applyStimulus(1, 8'h33, 0, 1, 2'd2, 0, 2'd0, 8'h00);
      applyStimulus(1, 8'h44, 0, 1, 2'd3, 0, 2'd0, 8'h00);
      checkState(3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 8'h55, 0, 0, 2'd0, 0, 2'd0, 8'h00);
      checkState(3'd4, 1'b1, 1'b0, 1'b1, 1'b0);

      // Drain back-to-back, then underflow.
      applyStimulus(0, 8'h00, 1, 0, 2'd0, 1, 2'd0, 8'h11);
      applyStimulus(0, 8'h00, 1, 0, 2'd0, 1, 2'd1, 8'h22);
      applyStimulus(0, 8'h00, 1, 0, 2'd0, 1, 2'd2, 8'h33);
      applyStimulus(0, 8'h00, 1, 0, 2'd0, 1, 2'd3, 8'h44);
      checkState(3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(0, 8'h00, 1, 0, 2'd0, 0, 2'd0, 8'h00);
      checkState(3'd0, 1'b0, 1'b1, 1'b1, 1'b1);

      // Interleaved push/pop across the pointer wrap.
      applyStimulus(1, 8'hA0, 0, 1, 2'd0, 0, 2'd0, 8'h00);
      applyStimulus(1, 8'hA1, 1, 1, 2'd1, 1, 2'd0, 8'hA0);
      applyStimulus(1, 8'hA2, 1, 1, 2'd2, 1, 2'd1, 8'hA1);
      applyStimulus(1, 8'hA3, 1, 1, 2'd3, 1, 2'd2, 8'hA2);
      applyStimulus(1, 8'hA4, 1, 1, 2'd0, 1, 2'd3, 8'hA3);
      applyStimulus(1, 8'hA5, 1, 1, 2'd1, 1, 2'd0, 8'hA4);
      checkState(3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 8'h00, 1, 0, 2'd0, 1, 2'd1, 8'hA5);
      checkState(3'd0, 1'b0, 1'b1, 1'b1, 1'b1);

      // Simultaneous push/pop at full and at empty.
      doReset();
      checkState(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1, 8'hB0, 0, 1, 2'd0, 0, 2'd0, 8'h00);
      applyStimulus(1, 8'hB1, 0, 1, 2'd1, 0, 2'd0, 8'h00);
      applyStimulus(1, 8'hB2, 0, 1, 2'd2, 0, 2'd0, 8'h00);
      applyStimulus(1, 8'hB3, 0, 1, 2'd3, 0, 2'd0, 8'h00);
      applyStimulus(1, 8'hC0, 1, 0, 2'd0, 1, 2'd0, 8'hB0);
      checkState(3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 8'h00, 1, 0, 2'd0, 1, 2'd1, 8'hB1);
      applyStimulus(0, 8'h00, 1, 0, 2'd0, 1, 2'd2, 8'hB2);
      applyStimulus(0, 8'h00, 1, 0, 2'd0, 1, 2'd3, 8'hB3);
      applyStimulus(1, 8'hD0, 1, 1, 2'd0, 0, 2'd0, 8'h00);
      checkState(3'd1, 1'b0, 1'b0, 1'b1, 1'b1);

      // Reset right after a pop is accepted: its data must never surface.
      applyStimulus(1, 8'hD1, 0, 1, 2'd1, 0, 2'd0, 8'h00);
      checkOutput("count_before_rst", 32'(count), 32'd2);
      pop = 1'b1;
      #1;
      checkOutput("read_en_before_rst", 32'(read_en), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      pop = 1'b0;
      expQ.delete();
      @(negedge clk);
      checkOutput("pop_valid_after_rst", 32'(pop_valid), 32'd0);
      checkState(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("WAdddr_after_rst", 32'(WAdddr), 32'd0);
      checkOutput("RAdddr_after_rst", 32'(RAdddr), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(1, 8'hE0, 0, 1, 2'd0, 0, 2'd0, 8'h00);
      applyStimulus(0, 8'h00, 1, 0, 2'd0, 1, 2'd0, 8'hE0);
      checkState(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
